// File: rtl/hog_cell_hist.sv
// hog_cell_hist
//   Accumulates per-cell HOG orientation histograms over one 8-pixel-high
//   cell-row, then drains them as CELLS_X*9 words before accepting more pixels.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   pixel sample present
//   in_ready   block accepts a sample this cycle (high only while accumulating)
//   in_sof     first pixel of a frame, qualified by in_valid
//   in_mag     unsigned gradient magnitude
//   in_bin     direction code; 0..8 are histogram bins, 9..15 are ignored
//   out_valid  histogram word present (high only while draining)
//   out_ready  downstream accepts the word
//   out_data   accumulated magnitude of bin out_bin in cell out_cell
//   out_cell   cell column index, 0..CELLS_X-1
//   out_bin    bin index, 0..8
//   out_last   final word of the cell-row drain
module hog_cell_hist #(
  parameter int IMG_W   = 64,
  parameter int CELLS_X = IMG_W / 8,
  parameter int ACC_W   = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [15:0]      in_mag,
  input  logic [3:0]       in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [7:0]       out_cell,
  output logic [3:0]       out_bin,
  output logic             out_last
);

  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int CW    = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
  localparam int NBINS = 9;

  localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(CELLS_X - 1);
  localparam logic [3:0]    BIN_LAST  = 4'd8;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [XW-1:0]    x;
  logic [2:0]       r;
  logic [CW-1:0]    dcell;
  logic [3:0]       dbin;
  logic [ACC_W-1:0] acc [CELLS_X][NBINS];

  logic             accept;
  logic             xfer;
  logic             row_end;
  logic             drain_end;
  logic             bin_ok;
  logic [CW-1:0]    cur_cell;

  // Widening add; the accumulator is sized so that a full cell of maximum
  // magnitudes cannot overflow, hence no saturation.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [15:0]      m);
    return a + {{(ACC_W-16){1'b0}}, m};
  endfunction

  function automatic logic [ACC_W-1:0] mag_ext(input logic [15:0] m);
    return {{(ACC_W-16){1'b0}}, m};
  endfunction

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign bin_ok    = (in_bin <= BIN_LAST);
  assign cur_cell  = CW'(x >> 3);
  // The sof sample counts as pixel (0,0), so it can never close a cell-row.
  assign row_end   = accept & ~in_sof & (x == X_LAST) & (r == 3'd7);
  assign drain_end = xfer & (dcell == CELL_LAST) & (dbin == BIN_LAST);

  // ---- control: FSM state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (row_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (drain_end) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // ---- control: pixel position within the cell-row ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      r <= '0;
    end else if (accept) begin
      if (in_sof) begin
        x <= XW'(1);
        r <= '0;
      end else if (x == X_LAST) begin
        x <= '0;
        r <= r + 3'd1;  // 7 wraps to 0 as the drain starts
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // ---- control: drain word pointer (cell outer, bin inner) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcell <= '0;
      dbin  <= '0;
    end else if (xfer) begin
      if (dbin == BIN_LAST) begin
        dbin  <= '0;
        dcell <= (dcell == CELL_LAST) ? '0 : dcell + CW'(1);
      end else begin
        dbin <= dbin + 4'd1;
      end
    end
  end

  // ---- datapath: histogram accumulators ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CELLS_X; c++)
        for (int b = 0; b < NBINS; b++)
          acc[c][b] <= '0;
    end else if (drain_end) begin
      for (int c = 0; c < CELLS_X; c++)
        for (int b = 0; b < NBINS; b++)
          acc[c][b] <= '0;
    end else if (accept) begin
      if (in_sof) begin
        // New frame: discard the partial row, keep only this pixel.
        for (int c = 0; c < CELLS_X; c++)
          for (int b = 0; b < NBINS; b++)
            acc[c][b] <= '0;
        if (bin_ok) acc[0][in_bin] <= mag_ext(in_mag);
      end else if (bin_ok) begin
        acc[cur_cell][in_bin] <= acc_add(acc[cur_cell][in_bin], in_mag);
      end
    end
  end

  // Accumulators are frozen during DRAIN, so the read stays stable under stall.
  assign out_data = (state == DRAIN) ? acc[dcell][dbin] : '0;
  assign out_cell = 8'(dcell);
  assign out_bin  = dbin;
  assign out_last = (state == DRAIN) & (dcell == CELL_LAST) & (dbin == BIN_LAST);

endmodule

// File: tb/tb_hog_cell_hist.sv
module tb_hog_cell_hist;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [15:0] in_mag;
  logic [3:0]  in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] out_data;
  logic [7:0]  out_cell;
  logic [3:0]  out_bin;
  logic        out_last;

  hog_cell_hist #(.IMG_W(64), .ACC_W(22)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_mag    (in_mag),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cell  (out_cell),
    .out_bin   (out_bin),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] w_data [80];
  logic [7:0]  w_cell [80];
  logic [3:0]  w_bin  [80];
  logic        w_last [80];
  int          n_words;
  int          to_flag;
  int          ir_bad;
  int          st_bad;
  int          stalled;

  // Hand-derived expected bin values for each stimulus pattern (64 pixels/cell).
  function automatic logic [21:0] exp_word(input int mode, input int k);
    int c = k / 9;
    int b = k % 9;
    case (mode)
      0: return (b == 2) ? 22'd64 : 22'd0;
      1: return (b == 8) ? 22'd4194240 : 22'd0;
      2: return 22'd0;
      3: return (b < 8) ? 22'(8 * (c + 1)) : 22'd0;
      default: return (b == 1) ? 22'd192 : 22'd0;
    endcase
  endfunction

  function automatic logic [34:0] exp_vec(input int mode, input int k);
    return {exp_word(mode, k), 8'(k / 9), 4'(k % 9), (k == 71)};
  endfunction

  task automatic feed_sample(input logic sof, input logic [15:0] mag, input logic [3:0] bin);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_mag   = mag;
    in_bin   = bin;
  endtask

  // Collects drain words; optionally stalls at word stall_idx for 5 cycles or
  // asserts rst when word abort_idx is presented.
  task automatic collect(input int stall_idx, input int abort_idx);
    logic [35:0] snap;
    n_words = 0; to_flag = 0; ir_bad = 0; st_bad = 0; stalled = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (out_valid) begin
        if (in_ready) ir_bad++;
        if (n_words == abort_idx) begin
          rst = 1'b1;
          return;
        end
        if (n_words == stall_idx && stalled == 0) begin
          stalled   = 1;
          snap      = {out_valid, out_data, out_cell, out_bin, out_last};
          out_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if ({out_valid, out_data, out_cell, out_bin, out_last} !== snap) st_bad++;
          end
          out_ready = 1'b1;
        end
        if (n_words < 80) begin
          w_data[n_words] = out_data;
          w_cell[n_words] = out_cell;
          w_bin[n_words]  = out_bin;
          w_last[n_words] = out_last;
        end
        n_words++;
        if (out_last) begin
          @(negedge clk);
          return;
        end
      end
      @(negedge clk);
    end
    to_flag = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_mag = '0; in_bin = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_last, out_data, out_cell, out_bin} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {out_valid, out_last, out_data, out_cell, out_bin});
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_bad++;
        $display("FAIL idle_cycle%0d: in_ready/out_valid got %b want 10", i, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_unit_mag(input string nm);
    for (int i = 0; i < 512; i++) feed_sample(1'b0, 16'd1, 4'd2);
    collect(-1, -1);
    n_cmp++;
    if (to_flag != 0 || n_words != 72) begin
      n_bad++;
      $display("FAIL %s_count: got %0d words (timeout=%0d) want 72", nm, n_words, to_flag);
    end
    for (int k = 0; k < 72; k++) begin
      n_cmp++;
      if ({w_data[k], w_cell[k], w_bin[k], w_last[k]} !== exp_vec(0, k)) begin
        n_bad++;
        $display("FAIL %s_word%0d: got %h want %h", nm, k, {w_data[k], w_cell[k], w_bin[k], w_last[k]}, exp_vec(0, k));
      end
    end
    n_cmp++;
    if (ir_bad != 0) begin
      n_bad++;
      $display("FAIL %s_in_ready_drain: got %0d cycles high want 0", nm, ir_bad);
    end
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL %s_after_drain: in_ready/out_valid got %b want 10", nm, {in_ready, out_valid});
    end
  endtask

  task automatic test_max_mag;
    for (int i = 0; i < 512; i++) feed_sample(1'b0, 16'hFFFF, 4'd8);
    collect(-1, -1);
    n_cmp++;
    if (to_flag != 0 || n_words != 72) begin
      n_bad++;
      $display("FAIL max_count: got %0d words (timeout=%0d) want 72", n_words, to_flag);
    end
    for (int k = 0; k < 72; k++) begin
      n_cmp++;
      if ({w_data[k], w_cell[k], w_bin[k], w_last[k]} !== exp_vec(1, k)) begin
        n_bad++;
        $display("FAIL max_word%0d: got %h want %h", k, {w_data[k], w_cell[k], w_bin[k], w_last[k]}, exp_vec(1, k));
      end
    end
  endtask

  task automatic test_invalid_bins;
    for (int i = 0; i < 512; i++) feed_sample(i == 0, 16'd100, 4'(9 + (i % 7)));
    collect(-1, -1);
    n_cmp++;
    if (to_flag != 0 || n_words != 72) begin
      n_bad++;
      $display("FAIL badbin_count: got %0d words (timeout=%0d) want 72", n_words, to_flag);
    end
    for (int k = 0; k < 72; k++) begin
      n_cmp++;
      if ({w_data[k], w_cell[k], w_bin[k], w_last[k]} !== exp_vec(2, k)) begin
        n_bad++;
        $display("FAIL badbin_word%0d: got %h want %h", k, {w_data[k], w_cell[k], w_bin[k], w_last[k]}, exp_vec(2, k));
      end
    end
  endtask

  // bin = pixel row, mag = cell+1: every word of the drain differs.
  task automatic test_stall;
    for (int i = 0; i < 512; i++) feed_sample(1'b0, 16'((i % 64) / 8 + 1), 4'(i / 64));
    collect(9, -1);
    n_cmp++;
    if (to_flag != 0 || n_words != 72) begin
      n_bad++;
      $display("FAIL stall_count: got %0d words (timeout=%0d) want 72", n_words, to_flag);
    end
    n_cmp++;
    if (stalled != 1 || st_bad != 0) begin
      n_bad++;
      $display("FAIL stall_stable: stalled=%0d unstable_cycles=%0d want 1/0", stalled, st_bad);
    end
    for (int k = 0; k < 72; k++) begin
      n_cmp++;
      if ({w_data[k], w_cell[k], w_bin[k], w_last[k]} !== exp_vec(3, k)) begin
        n_bad++;
        $display("FAIL stall_word%0d: got %h want %h", k, {w_data[k], w_cell[k], w_bin[k], w_last[k]}, exp_vec(3, k));
      end
    end
  endtask

  task automatic test_sof_then_reset;
    for (int i = 0; i < 100; i++) feed_sample(1'b0, 16'd5, 4'd0);
    feed_sample(1'b1, 16'd3, 4'd1);
    for (int i = 0; i < 511; i++) feed_sample(1'b0, 16'd3, 4'd1);
    collect(-1, 29);
    #1;
    n_cmp++;
    if (n_words != 29) begin
      n_bad++;
      $display("FAIL sof_abort_point: got %0d words want 29", n_words);
    end
    n_cmp++;
    if ({out_valid, out_last, out_data, out_cell, out_bin, in_ready} !== 37'd1) begin
      n_bad++;
      $display("FAIL sof_reset_outputs: got %h want 1", {out_valid, out_last, out_data, out_cell, out_bin, in_ready});
    end
    for (int k = 0; k < 29; k++) begin
      n_cmp++;
      if ({w_data[k], w_cell[k], w_bin[k], w_last[k]} !== exp_vec(4, k)) begin
        n_bad++;
        $display("FAIL sof_word%0d: got %h want %h", k, {w_data[k], w_cell[k], w_bin[k], w_last[k]}, exp_vec(4, k));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_bad++;
        $display("FAIL post_abort_idle%0d: in_ready/out_valid got %b want 10", i, {in_ready, out_valid});
      end
    end
  endtask

  initial begin
    test_reset;
    test_unit_mag("unit");
    test_max_mag;
    test_invalid_bins;
    test_stall;
    test_sof_then_reset;
    test_unit_mag("after_abort");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
